uart_tx_queue: RTL

Byte queue and pacer between a UART `Receiver` and a UART `Transmitter` in the man-in-the-middle relay path. It absorbs bursts of received bytes, one `valid` pulse per byte, into a FIFO. It replays them to the downstream `Transmitter` as single-cycle `en` pulses, spaced far enough apart that no frame is overwritten mid-transmission. One instance sits in front of each relay transmitter (BS→BG and BG→BS), replacing direct `valid`→`en` wiring.

---
 rtl/uart_pkg.sv | 7 +
 rtl/uart_tx_queue_if.sv | 17 +
 rtl/byte_fifo.sv | 47 ++++
 rtl/uart_tx_queue.sv | 63 ++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART timing constants and tx pacing FSM encoding
package uart_pkg;
  localparam int CLKS_PER_BIT = 434;
  localparam int FRAME_BITS = 11;
  localparam int GAP_CYCLES = CLKS_PER_BIT * FRAME_BITS;
  typedef enum logic {IDLE, GAP} tx_state_e;
endpackage

// File: rtl/uart_tx_queue_if.sv
// uart_tx_queue_if: byte ingress and paced transmitter egress of the relay queue
interface uart_tx_queue_if #(parameter int DEPTH = 16);
  logic                   in_valid;
  logic [7:0]             in_data;
  logic                   flush;
  logic                   clear_ovf;
  logic                   tx_en;
  logic [7:0]             tx_data;
  logic [$clog2(DEPTH):0] count;
  logic                   full;
  logic                   empty;
  logic                   overflow;
  modport master (output in_valid, in_data, flush, clear_ovf,
                  input  tx_en, tx_data, count, full, empty, overflow);
  modport slave  (input  in_valid, in_data, flush, clear_ovf,
                  output tx_en, tx_data, count, full, empty, overflow);
endinterface

// File: rtl/byte_fifo.sv
// byte_fifo: power-of-two byte FIFO with push/pop/flush and occupancy count
module byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [7:0]             wr_data,
  output logic [7:0]             rd_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  always_comb begin
    wptr_d  = flush ? '0 : push ? wptr_q + AW'(1) : wptr_q;
    rptr_d  = flush ? '0 : pop ? rptr_q + AW'(1) : rptr_q;
    count_d = flush ? '0 :
              (push && !pop) ? count_q + CW'(1) :
              (pop && !push) ? count_q - CW'(1) : count_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end
  // storage needs no reset: only entries below count are ever read
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= wr_data;
  end
  assign rd_data = mem_q[rptr_q];
  assign count   = count_q;
  assign full    = count_q == CW'(DEPTH);
  assign empty   = count_q == '0;
endmodule

// File: rtl/uart_tx_queue.sv
// uart_tx_queue: buffers received bytes and replays them as tx_en pulses
// spaced at least GAP_CYCLES apart so no transmitter frame is cut short
module uart_tx_queue #(
  parameter int DEPTH      = 16,
  parameter int GAP_CYCLES = uart_pkg::GAP_CYCLES
) (
  input logic          clk,
  input logic          rst_n,
  uart_tx_queue_if.slave q
);
  import uart_pkg::*;
  localparam int GW = $clog2(GAP_CYCLES);
  tx_state_e   state_q, state_d;
  logic [GW-1:0] cnt_q, cnt_d;
  logic        tx_en_q, tx_en_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        ovf_q, ovf_d;
  logic        pop, push, fifo_full, fifo_empty;
  logic [7:0]  rd_data;
  byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push   (push),
    .pop    (pop),
    .flush  (q.flush),
    .wr_data(q.in_data),
    .rd_data(rd_data),
    .count  (q.count),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );
  // flush blocks both ends of the queue but leaves a running gap alone
  always_comb begin
    pop       = state_q == IDLE && !fifo_empty && !q.flush;
    push      = q.in_valid && !q.flush && (!fifo_full || pop);
    state_d   = state_q == IDLE ? (pop ? GAP : IDLE) : (cnt_q == GW'(1) ? IDLE : GAP);
    cnt_d     = pop ? GW'(GAP_CYCLES - 1) : state_q == GAP ? cnt_q - GW'(1) : cnt_q;
    tx_en_d   = pop;
    tx_data_d = pop ? rd_data : tx_data_q;
    ovf_d     = (q.in_valid && !q.flush && fifo_full && !pop) ? 1'b1 :
                q.clear_ovf ? 1'b0 : ovf_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      tx_en_q   <= 1'b0;
      tx_data_q <= 8'h00;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tx_en_q   <= tx_en_d;
      tx_data_q <= tx_data_d;
      ovf_q     <= ovf_d;
    end
  end
  assign q.tx_en    = tx_en_q;
  assign q.tx_data  = tx_data_q;
  assign q.full     = fifo_full;
  assign q.empty    = fifo_empty;
  assign q.overflow = ovf_q;
endmodule
